// File: rtl/prime_sieve_table.sv
// rtl/prime_sieve_table.sv - sieve-of-Eratosthenes prime engine with ascending prime table; optional odd-only mode via SIEVE_SKIP_EVEN_EN
module prime_sieve_table #(
  parameter int N_MAX  = 511,
  parameter int DATA_W = 9,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] prime_number,
  output logic              loop,
  output logic              done,
  output logic [ADDR_W-1:0] prime_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // One extra bit on cand/m so stepping past N_MAX never wraps back into range.
  localparam int W1   = DATA_W + 1;
  localparam int SQ_W = 2 * W1;
  localparam int TI   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_SEARCH, S_EMIT, S_MARK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [W1-1:0]     cand_q, cand_d;
  logic [W1-1:0]     m_q, m_d;
  logic [DATA_W-1:0] pn_q, pn_d;
  logic [W1-1:0]     cand_step;
  logic [W1-1:0]     mark_step;
  logic [SQ_W-1:0]   cand_sq;
  logic [W1:0]       m_after;
  logic              emit_en;
  logic              mark_en;
  logic [N_MAX:0]    composite;
  logic [DATA_W-1:0] table_mem [DEPTH];

`ifdef SIEVE_SKIP_EVEN_EN
  // After 2 only odd candidates are visited, so odd primes only need their odd multiples marked.
  assign cand_step = (cand_q == W1'(2)) ? W1'(1) : W1'(2);
  assign mark_step = (cand_q == W1'(2)) ? cand_q : (cand_q << 1);
`else
  assign cand_step = W1'(1);
  assign mark_step = cand_q;
`endif

  assign cand_sq = SQ_W'(cand_q) * SQ_W'(cand_q);
  assign m_after = {1'b0, m_q} + {1'b0, mark_step};

  assign prime_number = pn_q;
  assign loop         = (state_q == S_SEARCH) || (state_q == S_DONE);
  assign done         = (state_q == S_DONE);

  // Next-state, next-candidate and strobe decode for the sieve walk.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    m_d     = m_q;
    pn_d    = pn_q;
    emit_en = 1'b0;
    mark_en = 1'b0;
    case (state_q)
      S_SEARCH: begin
        if (cand_q > W1'(N_MAX)) begin
          state_d = S_DONE;
          pn_d    = '0;
        end else if (composite[cand_q[DATA_W-1:0]]) begin
          cand_d = cand_q + cand_step;
        end else begin
          state_d = S_EMIT;
          pn_d    = cand_q[DATA_W-1:0];
        end
      end
      S_EMIT: begin
        emit_en = 1'b1;
        if (cand_sq <= SQ_W'(N_MAX)) begin
          state_d = S_MARK;
          m_d     = cand_sq[W1-1:0];
        end else begin
          state_d = S_SEARCH;
          cand_d  = cand_q + cand_step;
        end
      end
      S_MARK: begin
        mark_en = 1'b1;
        m_d     = m_after[W1-1:0];
        if (m_after > (W1+1)'(N_MAX)) begin
          state_d = S_SEARCH;
          cand_d  = cand_q + cand_step;
        end
      end
      default: begin
        pn_d = '0;
      end
    endcase
  end

  // Sieve state registers, composite bitmap and prime counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SEARCH;
      cand_q      <= W1'(2);
      m_q         <= '0;
      pn_q        <= DATA_W'(1);
      composite   <= '0;
      prime_count <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      m_q     <= m_d;
      pn_q    <= pn_d;
      if (mark_en) begin
        composite[m_q[DATA_W-1:0]] <= 1'b1;
      end
      if (emit_en) begin
        prime_count <= prime_count + ADDR_W'(1);
      end
    end
  end

  // Table write; contents are not reset because prime_count alone decides validity.
  always_ff @(posedge clk) begin
    if (emit_en && (prime_count < ADDR_W'(DEPTH))) begin
      table_mem[prime_count[TI-1:0]] <= cand_q[DATA_W-1:0];
    end
  end

  // Registered read port; unwritten or out-of-range entries read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if ((rd_addr < prime_count) && (rd_addr < ADDR_W'(DEPTH))) begin
      rd_data <= table_mem[rd_addr[TI-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_prime_sieve_table.sv
// tb/tb_prime_sieve_table.sv - self-checking bench for prime_sieve_table (also valid with SIEVE_SKIP_EVEN_EN)
module tb_prime_sieve_table;

  localparam int N_MAX  = 511;
  localparam int DATA_W = 9;
  localparam int ADDR_W = 13;
  localparam int DEPTH  = 128;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] prime_number;
  logic              loop;
  logic              done;
  logic [ADDR_W-1:0] prime_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  prime_sieve_table #(
    .N_MAX(N_MAX), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prime_number(prime_number), .loop(loop),
    .done(done), .prime_count(prime_count), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int primes [DEPTH];
  int np = 0;
  int exp_cycles_unit = 0;
  int exp_cycles_skip = 0;

  int idx = 0;
  bit prev_loop = 1'b1;
  bit prev_valid = 1'b0;
  int exp_rd = 0;
  bit done_seen = 1'b0;
  int done_cyc = 0;
  int cyc = 0;
  int got [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference sieve and expected run length from the algorithm's counting rules.
  initial begin
    bit comp [N_MAX+1];
    for (int i = 0; i <= N_MAX; i++) comp[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) primes[i] = 0;
    for (int p = 2; p <= N_MAX; p++) begin
      if (!comp[p]) begin
        primes[np] = p;
        np++;
        for (int q = p * p; q <= N_MAX; q += p) comp[q] = 1'b1;
      end
    end
    // Unit step: one SEARCH per candidate 2..N_MAX plus the terminal one, one EMIT per prime, marks p*p..N step p.
    exp_cycles_unit = (N_MAX - 1) + 1 + np;
    // Odd-only: candidates 2,3,5,..,N_MAX plus terminal, marks step 2p for odd p.
    exp_cycles_skip = 1 + ((N_MAX - 1) / 2) + 1 + np;
    for (int k = 0; k < np; k++) begin
      int p;
      p = primes[k];
      if (p * p <= N_MAX) begin
        exp_cycles_unit += (N_MAX - p * p) / p + 1;
        exp_cycles_skip += (p == 2) ? ((N_MAX - 4) / 2 + 1) : ((N_MAX - p * p) / (2 * p) + 1);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) cyc = 0;
    else cyc = cyc + 1;
  end

  // Continuous comparison of the stream, counter and read port against the reference.
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0;
      prev_loop = 1'b1;
      prev_valid = 1'b0;
      done_seen = 1'b0;
      got.delete();
    end else begin
      bit fall;
      int exp_cnt;
      fall = prev_loop && !loop;
      if (fall) begin
        if (idx >= np) begin
          chk("extra_prime", idx, np - 1);
        end else begin
          chk("prime_seq", int'(prime_number), primes[idx]);
        end
        got.push_back(int'(prime_number));
        idx++;
      end else if (!loop && idx > 0) begin
        chk("prime_held", int'(prime_number), primes[idx-1]);
      end
      exp_cnt = fall ? idx - 1 : idx;
      chk("prime_count", int'(prime_count), exp_cnt);
      if (done) begin
        chk("done_prime_zero", int'(prime_number), 0);
        chk("done_loop", int'(loop), 1);
        if (!done_seen) begin
          chk("done_total", idx, np);
          done_cyc = cyc;
          done_seen = 1'b1;
        end
      end else begin
        chk("running_nonzero", int'(prime_number != 0), 1);
      end
      if (prev_valid) chk("rd_data", int'(rd_data), exp_rd);
      exp_rd = ((int'(rd_addr) < exp_cnt) && (int'(rd_addr) < DEPTH)) ? primes[int'(rd_addr)] : 0;
      prev_valid = 1'b1;
      prev_loop = loop;
    end
  end

  task automatic rd_check(input int addr, input int exp, input string name);
    @(posedge clk);
    #1 rd_addr = ADDR_W'(addr);
    @(posedge clk);
    @(negedge clk);
    chk(name, int'(rd_data), exp);
  endtask

  initial begin
    int first6 [6];
    first6 = '{2, 3, 5, 7, 11, 13};
    rst_n = 1'b0;
    rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("model_count", np, 97);
    chk("model_p24", primes[24], 97);
    chk("model_p96", primes[96], 509);
    chk("rst_prime", int'(prime_number), 1);
    chk("rst_loop", int'(loop), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(prime_count), 0);
    chk("rst_rd", int'(rd_data), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5000 && got.size() < 26; i++) @(negedge clk);
    chk("wait_101", int'(got.size() >= 26), 1);
    for (int i = 0; i < 6; i++) chk("first_primes", (got.size() > i) ? got[i] : -1, first6[i]);
    chk("prime_26th", (got.size() >= 26) ? got[25] : -1, 101);

    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_prime", int'(prime_number), 1);
    chk("midrst_loop", int'(loop), 1);
    chk("midrst_count", int'(prime_count), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 40 && rd_data == '0; i++) @(negedge clk);
    chk("rd0_first", int'(rd_data), 2);
    chk("restart_first", (got.size() > 0) ? got[0] : -1, 2);

    for (int i = 0; i < 20000 && !done_seen; i++) @(negedge clk);
    chk("wait_done", int'(done_seen), 1);
`ifdef SIEVE_SKIP_EVEN_EN
    chk("run_cycles", done_cyc, exp_cycles_skip);
    chk("skip_shorter", int'(done_cyc < exp_cycles_unit), 1);
`else
    chk("run_cycles", done_cyc, exp_cycles_unit);
`endif
    chk("final_count", int'(prime_count), 97);
    chk("final_prime", int'(prime_number), 0);
    chk("final_done", int'(done), 1);
    chk("last_prime", (got.size() > 0) ? got[got.size()-1] : -1, 509);

    rd_check(0, 2, "rd_addr0");
    rd_check(24, 97, "rd_addr24");
    rd_check(96, 509, "rd_addr96");
    rd_check(97, 0, "rd_addr97");
    rd_check(200, 0, "rd_addr200");
    rd_check(1, 3, "rd_addr1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
